// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: default frame geometry and FSM state encoding.
package uart_rx_pkg;

    localparam int unsigned DefaultDataBits   = 8;
    localparam int unsigned DefaultOversample = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready byte handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int unsigned DataBits = DefaultDataBits
) ();

    logic [DataBits-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit; reset value is a parameter.
module uart_rx_sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetVal;
            q      <= ResetVal;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, mid-bit sampling, valid/ready output with
// framing and overrun error pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DefaultOversample,
    parameter int unsigned DATA_BITS  = DefaultDataBits
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     sample_tick,
    input  logic     rx_serial,
    uart_rx_if.master rx_bus,
    output logic     busy,
    output logic     frame_err,
    output logic     overrun_err
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    rx_state_e            state;
    logic [CntW-1:0]      cnt;
    logic [IdxW-1:0]      idx;
    logic [DATA_BITS-1:0] sh;
    logic                 rxs;

    uart_rx_sync_2ff #(
        .ResetVal (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_serial),
        .q     (rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            cnt             <= '0;
            idx             <= '0;
            sh              <= '0;
            busy            <= 1'b0;
            frame_err       <= 1'b0;
            overrun_err     <= 1'b0;
            rx_bus.rx_data  <= '0;
            rx_bus.rx_valid <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            // Acceptance clears valid; a delivery below in the same cycle overrides it.
            if (rx_bus.rx_valid && rx_bus.rx_ready) begin
                rx_bus.rx_valid <= 1'b0;
            end

            if (sample_tick) begin
                unique case (state)
                    StIdle: begin
                        if (!rxs) begin
                            state <= StStart;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (cnt == CntHalf) begin
                            cnt <= '0;
                            idx <= '0;
                            if (rxs) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end else begin
                                state <= StData;
                            end
                        end else begin
                            cnt <= cnt + CntOne;
                        end
                    end
                    StData: begin
                        if (cnt == CntLast) begin
                            cnt <= '0;
                            sh  <= {rxs, sh[DATA_BITS-1:1]};
                            if (idx == IdxLast) begin
                                state <= StStop;
                            end else begin
                                idx <= idx + IdxOne;
                            end
                        end else begin
                            cnt <= cnt + CntOne;
                        end
                    end
                    StStop: begin
                        if (cnt == CntLast) begin
                            cnt <= '0;
                            if (rxs) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                                if (!rx_bus.rx_valid || rx_bus.rx_ready) begin
                                    rx_bus.rx_data  <= sh;
                                    rx_bus.rx_valid <= 1'b1;
                                end else begin
                                    overrun_err <= 1'b1;
                                end
                            end else begin
                                state     <= StBreak;
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CntOne;
                        end
                    end
                    StBreak: begin
                        // Stay here while the line is held low so a break reports only once.
                        if (rxs) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
